// File: rtl/mdu_sched.sv
// Multiply/divide scheduler beside EX: owns HI/LO, runs radix-2 divide and shift-add multiply.
// Define MDU_FAST_MUL_EN for a single-cycle combinational multiply; divide is unaffected.
module mdu_sched #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_mul,
    input  logic              start_div,
    input  logic              is_signed,
    input  logic [DATA_W-1:0] op_a,
    input  logic [DATA_W-1:0] op_b,
    input  logic              hi_we,
    input  logic              lo_we,
    input  logic [DATA_W-1:0] wdata,
    input  logic              annul,
    output logic              stall_req,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

    logic [1:0]          state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [2*DATA_W-1:0] acc_q, acc_d;
    logic [2*DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0]   b_q, b_d;
    logic [DATA_W-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic                is_div_q, is_div_d;
    logic                neg_q, neg_d;
    logic                rem_neg_q, rem_neg_d;

    logic                start_any;
    logic                sign_a, sign_b;
    logic [DATA_W-1:0]   abs_a, abs_b;

    assign start_any = start_div | start_mul;
    assign sign_a    = is_signed & op_a[DATA_W-1];
    assign sign_b    = is_signed & op_b[DATA_W-1];
    assign abs_a     = sign_a ? -op_a : op_a;
    assign abs_b     = sign_b ? -op_b : op_b;

    // Divide: acc_q[DATA_W-1:0] is the partial remainder, a_q[DATA_W-1:0] shifts the
    // dividend out of its MSB while quotient bits enter at the LSB.
    logic [DATA_W:0]     shifted, diff;
    logic                ge;
    logic [DATA_W-1:0]   rem_step, quot_step, rem_fix, quot_fix;
    logic [2*DATA_W-1:0] prod_step, prod_fix;

    always_comb begin
        shifted   = {acc_q[DATA_W-1:0], a_q[DATA_W-1]};
        diff      = shifted - {1'b0, b_q};
        ge        = shifted >= {1'b0, b_q};
        rem_step  = ge ? diff[DATA_W-1:0] : shifted[DATA_W-1:0];
        quot_step = {a_q[DATA_W-2:0], ge};
        quot_fix  = neg_q ? -quot_step : quot_step;
        rem_fix   = rem_neg_q ? -rem_step : rem_step;
        prod_step = b_q[0] ? acc_q + a_q : acc_q;
        prod_fix  = neg_q ? -prod_step : prod_step;
    end

`ifdef MDU_FAST_MUL_EN
    logic [2*DATA_W-1:0] ext_a, ext_b, fast_prod;
    // Truncated 2W x 2W product of sign/zero-extended operands is exact for both modes.
    assign ext_a     = {{DATA_W{sign_a}}, op_a};
    assign ext_b     = {{DATA_W{sign_b}}, op_b};
    assign fast_prod = ext_a * ext_b;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        a_d       = a_q;
        b_d       = b_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        is_div_d  = is_div_q;
        neg_d     = neg_q;
        rem_neg_d = rem_neg_q;
        if (annul) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_div) begin
                        is_div_d  = 1'b1;
                        neg_d     = sign_a ^ sign_b;
                        rem_neg_d = sign_a;
                        cnt_d     = '0;
                        if (op_b == '0) begin
                            lo_d    = '1;
                            hi_d    = op_a;
                            state_d = DONE;
                        end else begin
                            acc_d   = '0;
                            a_d     = {{DATA_W{1'b0}}, abs_a};
                            b_d     = abs_b;
                            state_d = RUN;
                        end
                    end else if (start_mul) begin
`ifdef MDU_FAST_MUL_EN
                        {hi_d, lo_d} = fast_prod;
                        state_d      = DONE;
`else
                        is_div_d  = 1'b0;
                        neg_d     = sign_a ^ sign_b;
                        rem_neg_d = 1'b0;
                        cnt_d     = '0;
                        acc_d     = '0;
                        a_d       = {{DATA_W{1'b0}}, abs_a};
                        b_d       = abs_b;
                        state_d   = RUN;
`endif
                    end else begin
                        if (hi_we) hi_d = wdata;
                        if (lo_we) lo_d = wdata;
                    end
                end
                RUN: begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (is_div_q) begin
                        acc_d = {{DATA_W{1'b0}}, rem_step};
                        a_d   = {{DATA_W{1'b0}}, quot_step};
                    end else begin
                        acc_d = prod_step;
                        a_d   = a_q << 1;
                        b_d   = b_q >> 1;
                    end
                    if (cnt_q == LAST) begin
                        state_d = DONE;
                        if (is_div_q) {hi_d, lo_d} = {rem_fix, quot_fix};
                        else          {hi_d, lo_d} = prod_fix;
                    end
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            a_q       <= '0;
            b_q       <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            is_div_q  <= 1'b0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            a_q       <= a_d;
            b_q       <= b_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            is_div_q  <= is_div_d;
            neg_q     <= neg_d;
            rem_neg_q <= rem_neg_d;
        end
    end

    assign stall_req = ((state_q == IDLE) && start_any && !annul) || (state_q == RUN);
    assign busy      = state_q != IDLE;
    assign done      = (state_q == DONE) && !annul;
    assign hi_o      = hi_q;
    assign lo_o      = lo_q;
endmodule

// File: tb/tb_mdu_sched.sv
// Directed bench for mdu_sched: divide, multiply, divide-by-zero, annul, MTHI/MTLO and reset.
module tb_mdu_sched;
    logic        clk = 1'b0;
    logic        rst, start_mul, start_div, is_signed, hi_we, lo_we, annul;
    logic [31:0] op_a, op_b, wdata;
    logic        stall_req, busy, done;
    logic [31:0] hi_o, lo_o;

    int errors = 0;
    int checks = 0;

`ifdef MDU_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 33;
`endif

    mdu_sched dut (
        .clk      (clk),
        .rst      (rst),
        .start_mul(start_mul),
        .start_div(start_div),
        .is_signed(is_signed),
        .op_a     (op_a),
        .op_b     (op_b),
        .hi_we    (hi_we),
        .lo_we    (lo_we),
        .wdata    (wdata),
        .annul    (annul),
        .stall_req(stall_req),
        .busy     (busy),
        .done     (done),
        .hi_o     (hi_o),
        .lo_o     (lo_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Presents a start at T (a negedge), holds it through DONE, drops it one cycle later.
    task automatic do_op(input logic sd, input logic sm, input logic sg,
                         input logic [31:0] a, input logic [31:0] b, input logic we,
                         output int lat, output int stalls, output logic [31:0] hi_t1,
                         output logic [31:0] hi_r, output logic [31:0] lo_r,
                         output logic busy_after);
        @(negedge clk);
        start_div = sd; start_mul = sm; is_signed = sg; op_a = a; op_b = b;
        hi_we = we; wdata = 32'hDEADBEEF;
        #1;
        stalls = stall_req ? 1 : 0;
        lat = 0; hi_t1 = 'x; hi_r = 'x; lo_r = 'x;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            hi_we = 1'b0;
            if (i == 1) hi_t1 = hi_o;
            if (done) begin
                lat = i; hi_r = hi_o; lo_r = lo_o;
                break;
            end
            if (stall_req) stalls++;
        end
        @(negedge clk);
        start_div = 1'b0; start_mul = 1'b0;
        #1;
        busy_after = busy;
    endtask

    int          lat, stalls;
    logic [31:0] hi_t1, hi_r, lo_r;
    logic        busy_after, saw_done;

    initial begin
        rst = 1'b1; start_mul = 0; start_div = 0; is_signed = 0; hi_we = 0; lo_we = 0;
        annul = 0; op_a = 0; op_b = 0; wdata = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_stall", {31'b0, stall_req}, 32'd0);
        check("reset_busy", {31'b0, busy}, 32'd0);
        check("reset_done", {31'b0, done}, 32'd0);
        check("reset_hi", hi_o, 32'd0);
        check("reset_lo", lo_o, 32'd0);
        rst = 1'b0;

        do_op(1, 0, 0, 32'd100, 32'd7, 0, lat, stalls, hi_t1, hi_r, lo_r, busy_after);
        check("divu_lat", lat, 33);
        check("divu_stalls", stalls, 33);
        check("divu_lo", lo_r, 32'd14);
        check("divu_hi", hi_r, 32'd2);
        check("divu_no_restart", {31'b0, busy_after}, 32'd0);

        do_op(1, 0, 1, 32'hFFFFFFF9, 32'd2, 0, lat, stalls, hi_t1, hi_r, lo_r, busy_after);
        check("div_m7_2_lo", lo_r, 32'hFFFFFFFD);
        check("div_m7_2_hi", hi_r, 32'hFFFFFFFF);

        do_op(1, 0, 1, 32'd7, 32'hFFFFFFFE, 0, lat, stalls, hi_t1, hi_r, lo_r, busy_after);
        check("div_7_m2_lo", lo_r, 32'hFFFFFFFD);
        check("div_7_m2_hi", hi_r, 32'd1);

        do_op(0, 1, 1, 32'hFFFFFFFF, 32'd2, 0, lat, stalls, hi_t1, hi_r, lo_r, busy_after);
        check("mult_lat", lat, MUL_LAT);
        check("mult_stalls", stalls, MUL_LAT);
        check("mult_hi", hi_r, 32'hFFFFFFFF);
        check("mult_lo", lo_r, 32'hFFFFFFFE);
        check("mult_no_restart", {31'b0, busy_after}, 32'd0);

        do_op(0, 1, 0, 32'hFFFFFFFF, 32'd2, 0, lat, stalls, hi_t1, hi_r, lo_r, busy_after);
        check("multu_lat", lat, MUL_LAT);
        check("multu_hi", hi_r, 32'd1);
        check("multu_lo", lo_r, 32'hFFFFFFFE);

        do_op(1, 0, 0, 32'd5, 32'd0, 0, lat, stalls, hi_t1, hi_r, lo_r, busy_after);
        check("divz_lat", lat, 1);
        check("divz_stalls", stalls, 1);
        check("divz_lo", lo_r, 32'hFFFFFFFF);
        check("divz_hi", hi_r, 32'd5);
        check("divz_no_restart", {31'b0, busy_after}, 32'd0);

        // Annul a divide at T+10; HI/LO keep the divide-by-zero results.
        @(negedge clk);
        start_div = 1; is_signed = 1; op_a = 32'd1000; op_b = 32'd3;
        saw_done = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (done) saw_done = 1'b1;
        end
        annul = 1; start_div = 0;
        @(negedge clk);
        annul = 0;
        #1;
        check("annul_busy", {31'b0, busy}, 32'd0);
        check("annul_stall", {31'b0, stall_req}, 32'd0);
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (done) saw_done = 1'b1;
        end
        check("annul_no_done", {31'b0, saw_done}, 32'd0);
        check("annul_hi", hi_o, 32'd5);
        check("annul_lo", lo_o, 32'hFFFFFFFF);

        // Back-to-back MTHI then MTLO.
        @(negedge clk);
        hi_we = 1; wdata = 32'h12345678;
        #1;
        check("mthi_old_value", hi_o, 32'd5);
        @(negedge clk);
        hi_we = 0; lo_we = 1; wdata = 32'hCAFEBABE;
        #1;
        check("mthi_new_value", hi_o, 32'h12345678);
        check("mtlo_old_value", lo_o, 32'hFFFFFFFF);
        @(negedge clk);
        lo_we = 0;
        #1;
        check("mtlo_new_value", lo_o, 32'hCAFEBABE);

        // MTHI alongside a start is dropped; the divide runs.
        do_op(1, 0, 0, 32'd9, 32'd4, 1, lat, stalls, hi_t1, hi_r, lo_r, busy_after);
        check("we_with_start_hi_t1", hi_t1, 32'h12345678);
        check("we_with_start_lat", lat, 33);
        check("we_with_start_lo", lo_r, 32'd2);
        check("we_with_start_hi", hi_r, 32'd1);

        // Reset in the middle of RUN.
        @(negedge clk);
        start_div = 1; is_signed = 0; op_a = 32'd1000; op_b = 32'd3;
        repeat (5) @(negedge clk);
        #1;
        check("pre_rst_busy", {31'b0, busy}, 32'd1);
        rst = 1; start_div = 0;
        @(negedge clk);
        rst = 0;
        #1;
        check("rst_run_busy", {31'b0, busy}, 32'd0);
        check("rst_run_stall", {31'b0, stall_req}, 32'd0);
        check("rst_run_hi", hi_o, 32'd0);
        check("rst_run_lo", lo_o, 32'd0);
        repeat (3) @(negedge clk);
        check("rst_run_idle", {31'b0, busy}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mdu_sched.md
Name: mdu_sched

Overview:
- Multi-cycle multiply/divide scheduler beside the EX stage. It owns the HI/LO architectural registers.
- Sequences an iterative radix-2 divider and a shift-add multiplier.
- Raises a stall request to the pipeline controller while an operation runs, so the EX instruction is held until the result is ready.
- Also services MTHI/MTLO writes and supplies HI/LO to EX for MFHI/MFLO.

Parameters:
DATA_W, 32, operand/HI/LO width
CNT_W, 6, iteration counter width (must hold DATA_W)

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
start_mul  input  1  level; EX holds MULT/MULTU instruction
start_div  input  1  level; EX holds DIV/DIVU instruction
is_signed  input  1  1 = MULT/DIV, 0 = MULTU/DIVU
op_a  input  DATA_W  rs value (dividend / multiplicand)
op_b  input  DATA_W  rt value (divisor / multiplier)
hi_we  input  1  MTHI write strobe
lo_we  input  1  MTLO write strobe
wdata  input  DATA_W  MTHI/MTLO data
annul  input  1  flush; abort current operation
stall_req  output  1  to pipeline controller, stalls IF..EX
busy  output  1  state != IDLE
done  output  1  one-cycle completion pulse
hi_o  output  DATA_W  HI register
lo_o  output  DATA_W  LO register

Behaviour:
- Reset is synchronous, active-high: rst with clk. On reset: state=IDLE, counter=0, HI=LO=0, stall_req=0, busy=0, done=0.
- States: IDLE, RUN, DONE.
- IDLE:
  - If start_div or start_mul, latch operands: absolute values when is_signed, plus sign flags. Latch op type, clear the counter, go to RUN.
  - If both starts are high, divide wins.
- RUN: one iteration per cycle; counter increments. After iteration DATA_W-1, write HI/LO and go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE. The start still asserted during DONE is ignored; this prevents a restart while EX releases the instruction.
- stall_req is combinational: (IDLE and (start_div or start_mul) and not annul) or RUN. It is 0 in DONE.
- Latency: start seen in cycle T; RUN occupies T+1..T+32; HI/LO valid from T+33 (DONE). Stall covers T..T+32.
- Divide:
  - Restoring, one quotient bit per cycle.
  - Signed correction: quotient negated if the operand signs differ; remainder takes the dividend's sign.
  - LO=quotient, HI=remainder.
- Divide by zero (op_b==0 at start):
  - IDLE goes directly to DONE in one cycle, and stall_req is 1 only in T.
  - LO=32'hFFFFFFFF, HI=op_a.
  - No exception.
- Multiply:
  - Shift-add over 2*DATA_W accumulator; signed correction negates the 64-bit product when the signs differ.
  - {HI,LO}=product.
- MTHI/MTLO:
  - Accepted only in IDLE with no start asserted; HI/LO take the value next edge.
  - hi_o/lo_o show the old value in the write cycle.
  - Ignored in RUN/DONE.
- annul: in any state, return to IDLE next edge. HI/LO are unchanged and done=0. annul has priority over start and writes.
- Reset mid-operation: same as the reset values above; partial results are discarded.

Optional Feature:
- Macro MDU_FAST_MUL_EN.
- Defined:
  - Multiply uses a single-cycle combinational DATA_W x DATA_W product (signed or unsigned). IDLE goes directly to DONE.
  - {HI,LO} is written at the end of T, and stall_req is 1 only in cycle T.
  - Divide is unchanged.
- Undefined: multiply uses the 32-iteration shift-add path with the same timing as divide.

Test Plan:
- DIVU 100/7: start_div=1, is_signed=0 held until done -> stall_req 1 for 33 cycles, done at T+33, LO=14, HI=2; no second operation starts.
- DIV -7/2 signed -> LO=32'hFFFFFFFD (-3), HI=32'hFFFFFFFF (-1); DIV 7/-2 -> LO=-3, HI=1.
- MULT 32'hFFFFFFFF x 2 signed -> HI=32'hFFFFFFFF, LO=32'hFFFFFFFE. MULTU same operands -> HI=1, LO=32'hFFFFFFFE. Check at T+33, and at T+1 with MDU_FAST_MUL_EN.
- DIVU 5/0 -> done at T+1, stall_req only in T, LO=32'hFFFFFFFF, HI=5.
- Start DIV 1000/3 and assert annul at T+10 -> IDLE at T+11, stall_req=0, HI/LO keep their prior values, done never pulses.
- MTHI 32'h12345678 then MTLO 32'hCAFEBABE in back-to-back IDLE cycles -> hi_o updates the cycle after hi_we. A simultaneous start_div with hi_we -> the write is ignored and the divide starts. rst during RUN -> HI=LO=0, IDLE.
